// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational 32-bit ALU between two requesters.
// Round-robin grant into an issue register (S1) that drives the ALU, and a
// result register (S2) that returns the tagged response. Response-side
// backpressure stalls both stages. One operation per cycle is sustained.
module alu_arbiter #(
  parameter int WIDTH  = 32,
  parameter int OPW    = 4,
  parameter int MAX_OP = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_illegal,
  output logic             busy
);

  localparam logic [OPW-1:0] L_MAX_OP = OPW'(MAX_OP);

  // Opcodes beyond the last defined ALU operation are flagged, not rejected.
  function automatic logic f_is_illegal(input logic [OPW-1:0] op);
    return (op > L_MAX_OP);
  endfunction

  // Issue stage (S1)
  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic [OPW-1:0]   r_s1_op;
  logic             r_s1_id;
  logic             r_s1_illegal;

  // Result stage (S2)
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_s2_data;
  logic             r_s2_id;
  logic             r_s2_illegal;

  // Requester that won the most recent accepted transfer
  logic             r_last_grant;

  logic             w_grant;
  logic             w_s2_load;
  logic             w_s1_free;
  logic             w_req0_ready;
  logic             w_req1_ready;
  logic             w_accept;
  logic [WIDTH-1:0] w_acc_a;
  logic [WIDTH-1:0] w_acc_b;
  logic [OPW-1:0]   w_acc_op;

  // Round-robin choice: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    w_grant = 1'b0;
    case ({req1_valid, req0_valid})
      2'b01:   w_grant = 1'b0;
      2'b10:   w_grant = 1'b1;
      2'b11:   w_grant = ~r_last_grant;
      default: w_grant = 1'b0;
    endcase
  end

  // Pipeline advance and handshake: S1 empties into S2 whenever S2 is empty or draining.
  always_comb begin
    w_s2_load    = r_s1_valid & (~r_s2_valid | rsp_ready);
    w_s1_free    = ~r_s1_valid | w_s2_load;
    w_req0_ready = w_s1_free & ~w_grant & req0_valid & ~rst;
    w_req1_ready = w_s1_free &  w_grant & req1_valid & ~rst;
    w_accept     = w_req0_ready | w_req1_ready;
  end

  // Operand selection from the granted requester.
  always_comb begin
    w_acc_a  = req0_a;
    w_acc_b  = req0_b;
    w_acc_op = req0_op;
    if (w_grant) begin
      w_acc_a  = req1_a;
      w_acc_b  = req1_b;
      w_acc_op = req1_op;
    end else begin
      w_acc_a  = req0_a;
      w_acc_b  = req0_b;
      w_acc_op = req0_op;
    end
  end

  // Priority rotates only on an accepted transfer, so stalls keep fairness intact.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= 1'b1;
    end else if (w_accept) begin
      r_last_grant <= w_grant;
    end else begin
      r_last_grant <= r_last_grant;
    end
  end

  // Issue register: load on accept, empty when its content moves on with nothing behind it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid   <= 1'b0;
      r_s1_a       <= '0;
      r_s1_b       <= '0;
      r_s1_op      <= '0;
      r_s1_id      <= 1'b0;
      r_s1_illegal <= 1'b0;
    end else if (w_accept) begin
      r_s1_valid   <= 1'b1;
      r_s1_a       <= w_acc_a;
      r_s1_b       <= w_acc_b;
      r_s1_op      <= w_acc_op;
      r_s1_id      <= w_grant;
      r_s1_illegal <= f_is_illegal(w_acc_op);
    end else if (w_s2_load) begin
      r_s1_valid   <= 1'b0;
    end else begin
      r_s1_valid   <= r_s1_valid;
    end
  end

  // Result register: capture the ALU output on advance, clear once the consumer takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid   <= 1'b0;
      r_s2_data    <= '0;
      r_s2_id      <= 1'b0;
      r_s2_illegal <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_valid   <= 1'b1;
      r_s2_data    <= alu_out;
      r_s2_id      <= r_s1_id;
      r_s2_illegal <= r_s1_illegal;
    end else if (r_s2_valid & rsp_ready) begin
      r_s2_valid   <= 1'b0;
    end else begin
      r_s2_valid   <= r_s2_valid;
    end
  end

  // Output mapping: ALU operands straight from S1, response straight from S2.
  always_comb begin
    req0_ready  = w_req0_ready;
    req1_ready  = w_req1_ready;
    alu_a       = r_s1_a;
    alu_b       = r_s1_b;
    alu_op      = r_s1_op;
    rsp_valid   = r_s2_valid;
    rsp_id      = r_s2_id;
    rsp_data    = r_s2_data;
    rsp_illegal = r_s2_illegal;
    busy        = r_s1_valid | r_s2_valid;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single 32-bit integer ALU between two requesters: port 0 is the execute stage, port 1 is the address/branch-compare helper.
- Each requester issues {A, B, op} with a valid/ready handshake; the arbiter grants round-robin and feeds the ALU from a registered issue stage.
- The ALU result is captured in a result register and returned on one shared response bus, tagged with the requester ID.
- Two-stage pipeline, one operation per cycle sustained; backpressure from the response side stalls both stages.

Parameters:
WIDTH, 32, operand/result width
OPW, 4, ALU opcode width
MAX_OP, 8, highest legal opcode (4'b1000 = SRA); any opcode above this is flagged illegal

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle
req0_a  input  WIDTH  operand A
req0_b  input  WIDTH  operand B
req0_op  input  OPW  ALU opcode
req1_valid, req1_ready, req1_a, req1_b, req1_op  same as port 0, for requester 1
alu_a  output  WIDTH  ALU operand A, from the issue register
alu_b  output  WIDTH  ALU operand B, from the issue register
alu_op  output  OPW  ALU opcode, from the issue register
alu_out  input  WIDTH  combinational ALU result
rsp_valid  output  1  response available
rsp_ready  input  1  consumer takes the response
rsp_id  output  1  requester that issued the response
rsp_data  output  WIDTH  captured ALU result
rsp_illegal  output  1  opcode was > MAX_OP (rsp_data is then 0, as the ALU returns)
busy  output  1  s1_valid | s2_valid

Behaviour:
- Reset (rst=1 at clk edge): s1_valid=0, s2_valid=0, last_grant=1, all data registers cleared to 0.
  - Outputs after reset: alu_a=alu_b=0, alu_op=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_illegal=0, busy=0.
  - req*_ready is forced 0 while rst=1.
  - Reset mid-operation discards every in-flight operation; no response is emitted for them.
- Advance conditions:
  - s2_load = s1_valid & (!s2_valid | rsp_ready).
  - s1_free = !s1_valid | s2_load.
- Grant (combinational, round-robin):
  - Only one requester valid: that requester is granted.
  - Both valid: grant = !last_grant.
  - reqX_ready = s1_free & grant==X & reqX_valid & !rst. At most one ready is high per cycle.
  - last_grant updates only on an accepted transfer; a stall does not rotate priority.
- S1 (issue register):
  - On accept, capture {a, b, op, id}, set s1_valid=1, and set illegal = (op > MAX_OP).
  - If s2_load occurs and there is no accept, s1_valid becomes 0.
  - alu_a/alu_b/alu_op always reflect S1 contents.
- S2 (result register):
  - On s2_load, capture rsp_data=alu_out, rsp_id, rsp_illegal, and set s2_valid=1.
  - If rsp_valid & rsp_ready and there is no s2_load, s2_valid becomes 0.
  - rsp_valid = s2_valid.
- Latency: a request accepted in cycle N gives rsp_valid=1 in cycle N+2 when there is no backpressure.
- Throughput: 1 operation per cycle; back-to-back responses with no bubbles while rsp_ready=1.
- Backpressure:
  - rsp_valid=1 & rsp_ready=0: S2 holds; S1 holds if valid; ready deasserts once S1 is full.
  - All held values stay stable; no operation is dropped or duplicated.
- Simultaneous events: a response drain, S1→S2 move and new accept may all occur in the same cycle (full flow-through).
- Requester rules: a requester holds valid and its fields stable until ready. The arbiter does not check this rule.
- Ordering: responses return in acceptance order; rsp_id identifies the source.

Test Plan:
- Single op: after reset, req0 {A=5, B=7, op=0000}, rsp_ready=1 → req0_ready=1 in the request cycle; 2 cycles later rsp_valid=1, rsp_data=12, rsp_id=0, rsp_illegal=0; busy returns to 0 one cycle after the drain.
- Round-robin: both requesters held valid for 4 cycles (req0 SUB 10-3, req1 XOR F0^0F) → grants 0,1,0,1 starting with port 0; responses 7, FF, 7, FF with rsp_id 0,1,0,1, one per cycle.
- Backpressure: 3 back-to-back req0 ADDs (1+1, 2+2, 3+3), rsp_ready=0 for 4 cycles then 1 →
  - rsp_data holds 2 while stalled; req0_ready drops after 2 accepts.
  - Responses 2, 4, 6 arrive in order with none lost.
- Illegal opcode: req1 {A=9, B=9, op=1111} → rsp_data=0, rsp_illegal=1, rsp_id=1; a following legal op returns rsp_illegal=0.
- Reset mid-flight: accept 2 ops, assert rst for 1 cycle during the second → rsp_valid=0 and busy=0 after reset with no stale response; first request after reset goes to port 0 when both requesters are valid.
- Shift/signed passthrough: req0 {A=0x80000000, B=4, op=1000} → rsp_data=0xF8000000; op=0111 with the same operands → 0x08000000.
